wb_rr_bus_b3: RTL
=================

# wb_rr_bus_b3

Parametrised shared Wishbone B3 interconnect for multi-core mor1kx systems: N masters (instruction and data ports of each core) and M address-decoded slaves. It uses registered round-robin arbitration, burst-preserving grants and a bus-hold handshake. It also drives a write-snoop broadcast so per-core data caches can invalidate lines written by other masters. It sits between the CPU bus ports and the memory/UART slaves in the SoC top.

## Interface
- NUM_MASTERS, 4, number of masters (1..16)
- NUM_SLAVES, 2, number of slaves (1..8)
- DW, 32, data width; select width is DW/8
- S_BASE, {32'hff800000, 32'h00000000}, packed NUM_SLAVES×32 base addresses, slave i at bits [32i+31:32i]
- S_MASK, {32'hfffffff8, 32'hff800000}, packed NUM_SLAVES×32 decode masks
- TIMEOUT_CYCLES, 255, stall limit in cycles; used only with WB_BUS_TIMEOUT_EN
- wb_clk_i  in  1  bus clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- m_adr_i / m_dat_i / m_sel_i / m_we_i / m_cyc_i / m_stb_i / m_cti_i / m_bte_i  in  NUM_MASTERS× (32 / DW / DW/8 / 1 / 1 / 1 / 3 / 2)  packed master requests, master k at slice k
- m_dat_o / m_ack_o / m_err_o / m_rty_o  out  NUM_MASTERS× (DW / 1 / 1 / 1)  packed master responses
- s_adr_o / s_dat_o / s_sel_o / s_we_o / s_cyc_o / s_stb_o / s_cti_o / s_bte_o  out  NUM_SLAVES× (same widths)  packed slave requests
- s_dat_i / s_ack_i / s_err_i / s_rty_i  in  NUM_SLAVES× (DW / 1 / 1 / 1)  packed slave responses
- bus_hold  in  1  request to freeze arbitration
- bus_hold_ack  out  1  bus idle and held
- snoop_adr_o  out  32  address of the last acknowledged write
- snoop_en_o  out  1  one-cycle write-snoop strobe

## Operation
- FSM states: IDLE and GRANT. Registers: grant index, grant_valid, last-grant pointer.
- IDLE:
  - If bus_hold=0 and any m_cyc_i is set, pick the first requesting master scanning from (last+1) mod NUM_MASTERS upward with wrap.
  - Register the winner and go to GRANT. The winner becomes the new last pointer.
  - If bus_hold=1, no grant is made.
- GRANT:
  - The granted master's adr/dat/sel/we/cti/bte go combinationally to all slaves.
  - cyc/stb are driven only to the decoded slave: the lowest i with (adr & S_MASK[i]) == S_BASE[i].
  - The decoded slave's dat/ack/err/rty return only to the granted master. All other masters see ack/err/rty=0 and dat=0.
  - No slave match while stb=1: m_err_o is asserted to the granted master combinationally. No slave sees cyc.
  - The grant is held while the granted m_cyc_i=1, covering bursts (cti 3'b010) and multi-access cycles. A master's cyc drop returns the FSM to IDLE on the next edge.
- Snoop:
  - On any cycle with a granted stb & we & decoded slave ack, register snoop_adr_o <= granted adr and snoop_en_o <= 1 on the next edge. Otherwise snoop_en_o <= 0.
  - snoop_adr_o holds its value between strobes.
- bus_hold_ack is registered: it equals 1 on the edge after bus_hold=1 is seen in IDLE, and 0 otherwise.

## Timing
- Reset: state IDLE, grant_valid=0, last pointer=NUM_MASTERS-1 (so master 0 wins first), snoop_adr_o=0, snoop_en_o=0, bus_hold_ack=0.
  - All s_cyc_o/s_stb_o and m_ack_o/m_err_o/m_rty_o are 0 while reset is asserted and while IDLE.
- Arbitration latency: 1 cycle from m_cyc_i rise to the slave seeing cyc/stb.
- Re-arbitration gap: 1 IDLE cycle between consecutive grants, even to the same master.
- Response path is combinational: slave ack to master ack has 0 cycles added.
- Snoop latency: 1 cycle after the write ack.
- Granted master drops cyc mid-burst: slave cyc/stb fall the same cycle. The FSM returns to IDLE on the next edge.
- bus_hold rising during GRANT does not abort the transfer. It takes effect at the next IDLE.
- Asynchronous reset mid-transfer: all outputs go immediately to their reset values. The transfer is lost.

## Configuration
- WB_BUS_TIMEOUT_EN defined:
  - An 8..16-bit counter increments on each GRANT cycle with stb=1 and no ack/err/rty from the slave. It clears on any response or on leaving GRANT.
  - When the count reaches TIMEOUT_CYCLES, m_err_o pulses to the granted master for one cycle and s_stb_o is forced to 0 that cycle.
- WB_BUS_TIMEOUT_EN undefined: no counter. A non-responding slave stalls the bus indefinitely.

## Test plan
- Masters 0 and 2 raise cyc in the same cycle from reset -> master 0 granted 1 cycle later. After master 0 drops cyc, master 2 is granted after 1 IDLE cycle.
- All 4 masters hold cyc continuously, each doing one single access -> grant order 0,1,2,3,0.
- Master 1 runs a 4-beat incrementing burst (cti 010,010,010,111) to 0x100 -> grant held for all beats, no other grant, 4 acks on master 1 only.
- Master 3 writes 0x12345678 to 0x00000200 -> mem slave acked, snoop_en_o=1 for exactly 1 cycle with snoop_adr_o=0x00000200.
- Read from 0x80000000 (no slave match) -> m_err_o=1 in the cycle of stb, no s_cyc_o asserted.
- With WB_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, UART slave never acks -> m_err_o pulses on the 16th stalled cycle. Repeat with bus_hold=1 in IDLE -> bus_hold_ack=1 next cycle and no grant while held.

Source files
------------

// File: rtl/wb_rr_bus_b3.sv
// wb_rr_bus_b3: shared Wishbone B3 interconnect. NUM_MASTERS masters are
// arbitrated round-robin onto NUM_SLAVES address-decoded slaves. The grant is
// held for as long as the granted master keeps cyc high. A write-snoop strobe
// is broadcast for cache invalidation.
// Optional feature: define WB_BUS_TIMEOUT_EN to error out stalled accesses
// after TIMEOUT_CYCLES.
module wb_rr_bus_b3 #(
  parameter int unsigned               NUM_MASTERS    = 4,
  parameter int unsigned               NUM_SLAVES     = 2,
  parameter int unsigned               DW             = 32,
  parameter logic [NUM_SLAVES*32-1:0]  S_BASE         = {32'hff800000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0]  S_MASK         = {32'hfffffff8, 32'hff800000},
  parameter int unsigned               TIMEOUT_CYCLES = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic [NUM_MASTERS*32-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
  output logic [NUM_MASTERS*DW-1:0]     m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [NUM_SLAVES*32-1:0]      s_adr_o,
  output logic [NUM_SLAVES*DW-1:0]      s_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0]    s_sel_o,
  output logic [NUM_SLAVES-1:0]         s_we_o,
  output logic [NUM_SLAVES-1:0]         s_cyc_o,
  output logic [NUM_SLAVES-1:0]         s_stb_o,
  output logic [NUM_SLAVES*3-1:0]       s_cti_o,
  output logic [NUM_SLAVES*2-1:0]       s_bte_o,
  input  logic [NUM_SLAVES*DW-1:0]      s_dat_i,
  input  logic [NUM_SLAVES-1:0]         s_ack_i,
  input  logic [NUM_SLAVES-1:0]         s_err_i,
  input  logic [NUM_SLAVES-1:0]         s_rty_i,
  input  logic                          bus_hold,
  output logic                          bus_hold_ack,
  output logic [31:0]                   snoop_adr_o,
  output logic                          snoop_en_o
);

  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic            grant_valid_q, grant_valid_d;
  logic            hold_ack_q, hold_ack_d;
  logic [31:0]     snoop_adr_q, snoop_adr_d;
  logic            snoop_en_q, snoop_en_d;

  logic [31:0]     g_adr;
  logic [DW-1:0]   g_dat;
  logic [DW/8-1:0] g_sel;
  logic [2:0]      g_cti;
  logic [1:0]      g_bte;
  logic            g_we, g_cyc, g_stb;
  logic            hit;
  logic [SW-1:0]   sidx;
  logic [DW-1:0]   sl_dat;
  logic            sl_ack, sl_err, sl_rty;
  logic            win_found;
  logic [GW-1:0]   win;
  logic            tmo_fire;

  // Select the granted master's request fields
  always_comb begin
    g_adr = m_adr_i[grant_q*32 +: 32];
    g_dat = m_dat_i[grant_q*DW +: DW];
    g_sel = m_sel_i[grant_q*(DW/8) +: DW/8];
    g_cti = m_cti_i[grant_q*3 +: 3];
    g_bte = m_bte_i[grant_q*2 +: 2];
    g_we  = m_we_i[grant_q];
    g_cyc = grant_valid_q & m_cyc_i[grant_q];
    g_stb = g_cyc & m_stb_i[grant_q];
  end

  // Address decode: lowest-numbered matching slave wins
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((g_adr & S_MASK[i*32 +: 32]) == S_BASE[i*32 +: 32])) begin
        hit  = 1'b1;
        sidx = SW'(i);
      end
    end
    sl_dat = s_dat_i[sidx*DW +: DW];
    sl_ack = s_ack_i[sidx];
    sl_err = s_err_i[sidx];
    sl_rty = s_rty_i[sidx];
  end

  // Round-robin pick: first requester after the last winner, with wrap
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win       = last_q;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = (32'(last_q) + i) % NUM_MASTERS;
      if (!win_found && m_cyc_i[idx]) begin
        win_found = 1'b1;
        win       = GW'(idx);
      end
    end
  end

`ifdef WB_BUS_TIMEOUT_EN
  localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TW = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          stall;

  // Stall counter: the TIMEOUT_CYCLES-th consecutive unanswered strobe fires the error
  always_comb begin
    stall    = g_stb & hit & ~(sl_ack | sl_err | sl_rty);
    tmo_fire = stall & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    tmo_d    = tmo_q;
    if (!grant_valid_q || !stall || tmo_fire) tmo_d = '0;
    else                                       tmo_d = tmo_q + TW'(1);
  end

  // Stall counter register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) tmo_q <= '0;
    else            tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Slave request fan-out and response return to the granted master
  always_comb begin
    s_adr_o = {NUM_SLAVES{g_adr}};
    s_dat_o = {NUM_SLAVES{g_dat}};
    s_sel_o = {NUM_SLAVES{g_sel}};
    s_we_o  = {NUM_SLAVES{g_we}};
    s_cti_o = {NUM_SLAVES{g_cti}};
    s_bte_o = {NUM_SLAVES{g_bte}};
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (g_cyc) begin
      if (hit) begin
        s_cyc_o[sidx]                = 1'b1;
        s_stb_o[sidx]                = g_stb & ~tmo_fire;
        m_dat_o[grant_q*DW +: DW]    = sl_dat;
        m_ack_o[grant_q]             = sl_ack;
        m_err_o[grant_q]             = sl_err | tmo_fire;
        m_rty_o[grant_q]             = sl_rty;
      end else begin
        m_err_o[grant_q]             = g_stb;
      end
    end
  end

  // Arbitration FSM next state, hold handshake and snoop capture
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    hold_ack_d  = 1'b0;
    snoop_en_d  = g_stb & g_we & hit & sl_ack;
    snoop_adr_d = snoop_en_d ? g_adr : snoop_adr_q;
    case (state_q)
      IDLE: begin
        hold_ack_d = bus_hold;
        if (!bus_hold && win_found) begin
          state_d = GRANT;
          grant_d = win;
          last_d  = win;
        end
      end
      GRANT: if (!g_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grant_valid_d = (state_d == GRANT);
  end

  // State registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_q        <= GW'(NUM_MASTERS - 1);
      grant_valid_q <= 1'b0;
      hold_ack_q    <= 1'b0;
      snoop_adr_q   <= '0;
      snoop_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      grant_valid_q <= grant_valid_d;
      hold_ack_q    <= hold_ack_d;
      snoop_adr_q   <= snoop_adr_d;
      snoop_en_q    <= snoop_en_d;
    end
  end

  assign bus_hold_ack = hold_ack_q;
  assign snoop_adr_o  = snoop_adr_q;
  assign snoop_en_o   = snoop_en_q;

endmodule
